// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle MIPS-subset control path.
// Holds the opcode constants, the ALUOp classes (also used by the ALU
// controller), the 4-bit FSM state encoding and the datapath mux encodings.
package ctrl_pkg;

  // Opcode field values
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  // ALU operation classes handed to the ALU controller
  localparam logic [2:0] ALUOP_RTYPE = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b001;
  localparam logic [2:0] ALUOP_ORI   = 3'b010;
  localparam logic [2:0] ALUOP_BNE   = 3'b011;
  localparam logic [2:0] ALUOP_BEQ   = 3'b100;
  localparam logic [2:0] ALUOP_SLTI  = 3'b101;
  localparam logic [2:0] ALUOP_LUI   = 3'b110;

  // ALU operand B select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // FSM states; codes 12..15 are unused and recover to S_FETCH
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_op_enc.sv
// alu_op_enc: combinational ALUOp encoder.
// Maps (state, latched opcode) to the 3-bit ALU class for the ALU controller.
//   i_state  : current FSM state
//   i_op     : opcode latched in DECODE
//   o_alu_op : ALUOp class; 000 in states that do not use the ALU
module alu_op_enc
  import ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_op,
  output logic [2:0]  o_alu_op
);

  always_comb begin
    o_alu_op = ALUOP_RTYPE;
    case (i_state)
      // PC+4 in FETCH, branch target in DECODE, address in MEM_ADDR
      S_FETCH, S_DECODE, S_MEM_ADDR: o_alu_op = ALUOP_ADD;
      S_EXEC_R:                      o_alu_op = ALUOP_RTYPE;
      S_EXEC_I: begin
        case (i_op)
          OP_SLTI: o_alu_op = ALUOP_SLTI;
          OP_ORI:  o_alu_op = ALUOP_ORI;
          OP_LUI:  o_alu_op = ALUOP_LUI;
          default: o_alu_op = ALUOP_ADD;   // ADDI
        endcase
      end
      S_BRANCH: o_alu_op = (i_op == OP_BNE) ? ALUOP_BNE : ALUOP_BEQ;
      default:  o_alu_op = ALUOP_RTYPE;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// main_ctrl_fsm: multi-cycle main control unit for the MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/write-back and drives the datapath
// selects and strobes. Memory uses a variable-latency req/ack handshake.
// Ports:
//   clk_i, rst_i (async, active-low)
//   instr_op_i  : IR opcode, valid from DECODE onward
//   zero_i      : branch condition true
//   mem_ack_i   : memory completes current request this cycle
//   mem_read_o / mem_write_o / iord_o          : memory request + address select
//   ir_write_o / pc_write_o / reg_write_o      : strobes
//   reg_dst_o / mem_to_reg_o / alu_src_a_o / alu_src_b_o / pc_src_o : selects
//   alu_op_o    : ALU class for the ALU controller
//   illegal_o   : pulse on unsupported opcode (DECODE)
//   instr_done_o: pulse on retirement
//   state_o     : current state code (debug)
module main_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic [2:0] alu_op_o,
  output logic       illegal_o,
  output logic       instr_done_o,
  output logic [3:0] state_o
);

  state_t     r_state;
  logic [5:0] r_op;

  state_t     w_next;
  logic       w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write;
  logic       w_reg_write, w_reg_dst, w_mem_to_reg, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_pc_src;
  logic       w_illegal, w_done;
  logic [2:0] w_alu_op;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      // Later states decode the latched copy; the IR may change after DECODE.
      if (r_state == S_DECODE) r_op <= instr_op_i;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_RT;
    w_pc_src     = PCSRC_ALU;
    w_illegal    = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_FOUR;
        if (mem_ack_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_alu_src_b = SRCB_IMM_SH;
        case (instr_op_i)
          OP_LW, OP_SW:                      w_next = S_MEM_ADDR;
          OP_R:                              w_next = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_ORI, OP_LUI:  w_next = S_EXEC_I;
          OP_BEQ, OP_BNE:                    w_next = S_BRANCH;
          OP_J:                              w_next = S_JUMP;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        w_iord     = 1'b1;
        if (mem_ack_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_done       = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
        if (mem_ack_i) begin
          w_done = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_EXEC_R: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_RT;
        w_next      = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_EXEC_I: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
        w_next      = S_I_WB;
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_RT;
        w_pc_src    = PCSRC_ALUOUT;
        w_pc_write  = zero_i;
        w_done      = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write = 1'b1;
        w_pc_src   = PCSRC_JUMP;
        w_done     = 1'b1;
        w_next     = S_FETCH;
      end
      default: w_next = S_FETCH;   // unused codes: all outputs stay 0
    endcase
  end

  alu_op_enc u_alu_op_enc (
    .i_state  (r_state),
    .i_op     (r_op),
    .o_alu_op (w_alu_op)
  );

  // Reset gates every output combinationally so an in-flight request or
  // strobe is dropped the moment rst_i falls, not at the next edge.
  assign mem_read_o   = rst_i & w_mem_read;
  assign mem_write_o  = rst_i & w_mem_write;
  assign iord_o       = rst_i & w_iord;
  assign ir_write_o   = rst_i & w_ir_write;
  assign pc_write_o   = rst_i & w_pc_write;
  assign reg_write_o  = rst_i & w_reg_write;
  assign reg_dst_o    = rst_i & w_reg_dst;
  assign mem_to_reg_o = rst_i & w_mem_to_reg;
  assign alu_src_a_o  = rst_i & w_alu_src_a;
  assign alu_src_b_o  = {2{rst_i}} & w_alu_src_b;
  assign pc_src_o     = {2{rst_i}} & w_pc_src;
  assign alu_op_o     = {3{rst_i}} & w_alu_op;
  assign illegal_o    = rst_i & w_illegal;
  assign instr_done_o = rst_i & w_done;
  assign state_o      = r_state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Scoreboard bench: the program generator pushes the expected per-cycle
// output word of every instruction into exp_q; a memory responder supplies
// opcodes/acks; a monitor pops and compares one word per DUT cycle.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = '0;
  logic       zero = 1'b0;
  logic       ack = 1'b0;

  logic       mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_src_o;
  logic [2:0] alu_op_o;
  logic       illegal_o, instr_done_o;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  main_ctrl_fsm dut (
    .clk_i(clk), .rst_i(rst_n), .instr_op_i(op), .zero_i(zero), .mem_ack_i(ack),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .iord_o(iord_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .pc_src_o(pc_src_o), .alu_op_o(alu_op_o),
    .illegal_o(illegal_o), .instr_done_o(instr_done_o), .state_o(state_o)
  );

  int n_cmp = 0, n_err = 0;
  int inst_no = 0, n_gen = 0;
  logic [21:0] exp_q[$];
  int op_fifo[$];
  bit zero_fifo[$];
  int dly_fifo[$];
  bit rsp_en = 1'b0, mon_en = 1'b0, idle_ack = 1'b1;
  bit busy = 1'b0, hold = 1'b0;
  int cnt = 0;

  // Expected output word: {state, mem_read, mem_write, iord, ir_write,
  // pc_write, reg_write, reg_dst, mem_to_reg, srcA, srcB, pc_src, aluop,
  // illegal, done}
  function automatic logic [21:0] cyc(int st, bit mr, bit mw, bit io, bit irw,
      bit pcw, bit rw, bit rd, bit m2r, bit sa, int sb, int ps, int ao,
      bit ill, bit dn);
    logic [3:0] s; logic [1:0] b, p; logic [2:0] a;
    s = st[3:0]; b = sb[1:0]; p = ps[1:0]; a = ao[2:0];
    return {s, mr, mw, io, irw, pcw, rw, rd, m2r, sa, b, p, a, ill, dn};
  endfunction

  function automatic logic [21:0] dut_word();
    return {state_o, mem_read_o, mem_write_o, iord_o, ir_write_o, pc_write_o,
            reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
            pc_src_o, alu_op_o, illegal_o, instr_done_o};
  endfunction

  task automatic check(string name, logic [21:0] got, logic [21:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Reference model: spell out the cycle-by-cycle outputs of one instruction
  // from its opcode, branch flag and memory wait counts.
  task automatic gen(int o, bit z, int df, int dm);
    bit legal;
    legal = (o inside {0, 2, 4, 5, 8, 10, 13, 15, 35, 43});
    op_fifo.push_back(o); zero_fifo.push_back(z); dly_fifo.push_back(df);
    n_gen++;
    for (int i = 0; i < df; i++) exp_q.push_back(cyc(0,1,0,0,0,0,0,0,0,0,1,0,1,0,0));
    exp_q.push_back(cyc(0,1,0,0,1,1,0,0,0,0,1,0,1,0,0));
    exp_q.push_back(cyc(1,0,0,0,0,0,0,0,0,0,3,0,1,!legal,0));
    case (o)
      35: begin
        dly_fifo.push_back(dm);
        exp_q.push_back(cyc(2,0,0,0,0,0,0,0,0,1,2,0,1,0,0));
        for (int i = 0; i <= dm; i++) exp_q.push_back(cyc(3,1,0,1,0,0,0,0,0,0,0,0,0,0,0));
        exp_q.push_back(cyc(4,0,0,0,0,0,1,0,1,0,0,0,0,0,1));
      end
      43: begin
        dly_fifo.push_back(dm);
        exp_q.push_back(cyc(2,0,0,0,0,0,0,0,0,1,2,0,1,0,0));
        for (int i = 0; i < dm; i++) exp_q.push_back(cyc(5,0,1,1,0,0,0,0,0,0,0,0,0,0,0));
        exp_q.push_back(cyc(5,0,1,1,0,0,0,0,0,0,0,0,0,0,1));
      end
      0: begin
        exp_q.push_back(cyc(6,0,0,0,0,0,0,0,0,1,0,0,0,0,0));
        exp_q.push_back(cyc(7,0,0,0,0,0,1,1,0,0,0,0,0,0,1));
      end
      8, 10, 13, 15: begin
        exp_q.push_back(cyc(8,0,0,0,0,0,0,0,0,1,2,0,
                            (o == 8) ? 1 : (o == 10) ? 5 : (o == 13) ? 2 : 6, 0, 0));
        exp_q.push_back(cyc(9,0,0,0,0,0,1,0,0,0,0,0,0,0,1));
      end
      4, 5: exp_q.push_back(cyc(10,0,0,0,0,z,0,0,0,1,0,1,(o == 4) ? 4 : 3,0,1));
      2:    exp_q.push_back(cyc(11,0,0,0,0,1,0,0,0,0,0,2,0,0,1));
      default: ;
    endcase
  endtask

  // Memory/IR responder: acks after the scheduled wait, loads the next
  // opcode on a fetch ack, holds it through DECODE, then scrambles it.
  always @(negedge clk) begin
    if (!rsp_en) begin
      busy = 1'b0; hold = 1'b0; ack = idle_ack;
    end else begin
      if (mem_read_o || mem_write_o) begin
        if (!busy && dly_fifo.size() > 0) begin busy = 1'b1; cnt = dly_fifo.pop_front(); end
        if (busy && cnt == 0) begin ack = 1'b1; busy = 1'b0; end
        else begin ack = 1'b0; if (busy) cnt--; end
      end else begin
        ack = 1'($urandom_range(0, 1));   // must be ignored
      end
      if (ack && mem_read_o && !iord_o && op_fifo.size() > 0) begin
        op = 6'(op_fifo.pop_front());
        zero = zero_fifo.pop_front();
        hold = 1'b1;
      end else if (hold) begin
        hold = 1'b0;
      end else begin
        op = 6'($urandom);
      end
    end
  end

  // Monitor: one expected word per cycle while the program runs.
  always @(negedge clk) begin
    if (mon_en) begin
      #1;
      if (exp_q.size() > 0) begin
        check($sformatf("instr%0d_cycle", inst_no), dut_word(), exp_q.pop_front());
        if (instr_done_o || illegal_o) inst_no++;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ops[14];
    bit found;
    ops = '{0, 2, 4, 5, 8, 10, 13, 15, 35, 43, 1, 63, 16, 34};

    // Directed program, then random instructions.
    gen(35, 0, 1, 0);  gen(43, 0, 0, 3);
    gen(4, 1, 0, 0);   gen(5, 0, 0, 0);  gen(4, 0, 2, 0);  gen(5, 1, 0, 0);
    gen(8, 0, 0, 0);   gen(10, 0, 0, 0); gen(13, 0, 1, 0); gen(15, 0, 0, 0);
    gen(0, 0, 0, 0);   gen(2, 0, 0, 0);  gen(63, 0, 0, 0); gen(35, 1, 2, 3);
    for (int i = 0; i < 70; i++)
      gen(ops[$urandom_range(0, 13)], 1'($urandom_range(0, 1)),
          $urandom_range(0, 3), $urandom_range(0, 3));

    // Reset held with ack asserted: everything must read 0.
    repeat (3) begin @(negedge clk); #1; check("reset_outputs", dut_word(), '0); end
    @(negedge clk); idle_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 check("first_fetch_req", dut_word(), cyc(0,1,0,0,0,0,0,0,0,0,1,0,1,0,0));
    @(posedge clk); rsp_en = 1'b1; mon_en = 1'b1;

    for (int c = 0; c < 20000 && exp_q.size() > 0; c++) @(posedge clk);
    n_cmp++;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL program_timeout: %0d expected cycles left", exp_q.size());
    end
    n_cmp++;
    if (inst_no != n_gen) begin
      n_err++;
      $display("FAIL retired_count: got %0d expected %0d", inst_no, n_gen);
    end
    @(negedge clk); mon_en = 1'b0;

    // Reset mid-instruction while a load is waiting in MEM_RD.
    op_fifo.push_back(35); zero_fifo.push_back(0);
    dly_fifo.push_back(0); dly_fifo.push_back(10);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk); #1;
      if (mem_read_o && iord_o) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin n_err++; $display("FAIL reach_mem_rd: got 0 expected 1"); end
    #1 rst_n = 1'b0;
    #1 check("midreset_outputs", dut_word(), '0);
    idle_ack = 1'b0; rsp_en = 1'b0;
    dly_fifo.delete(); op_fifo.delete(); zero_fifo.delete();
    @(negedge clk); #1 check("midreset_hold", dut_word(), '0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1 check("fetch_after_reset", dut_word(), cyc(0,1,0,0,0,0,0,0,0,0,1,0,1,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/main_ctrl_fsm.md
# main_ctrl_fsm

Multi-cycle main control unit for the single-issue MIPS-subset datapath. It sequences fetch, decode, execute, memory and write-back, and drives the datapath select and strobe signals. It produces the 3-bit `ALUOp` code that the ALU controller consumes. The ALU controller maps that code, plus `funct`, onto the ALU operation. Memory accesses use a variable-latency request/acknowledge handshake.

## Interface
- No parameters.
- `clk_i` in 1: single clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `instr_op_i` in 6: opcode field of the external instruction register; valid from DECODE onward.
- `zero_i` in 1: ALU zero flag; 1 means the branch condition is true for both BEQ (ALUOp 100) and BNE (ALUOp 011).
- `mem_ack_i` in 1: memory completes the current read or write in this cycle.
- `mem_read_o` out 1: memory read request.
- `mem_write_o` out 1: memory write request.
- `iord_o` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write_o` out 1: load the instruction register.
- `pc_write_o` out 1: load the PC.
- `reg_write_o` out 1: register file write.
- `reg_dst_o` out 1: destination register; 1 = rd, 0 = rt.
- `mem_to_reg_o` out 1: write-back data select; 1 = MDR, 0 = ALUOut.
- `alu_src_a_o` out 1: ALU operand A; 0 = PC, 1 = rs.
- `alu_src_b_o` out 2: ALU operand B; 00 = rt, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `pc_src_o` out 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op_o` out 3: ALU operation class passed to the ALU controller.
- `illegal_o` out 1: one-cycle pulse on an unsupported opcode.
- `instr_done_o` out 1: one-cycle pulse when an instruction retires.
- `state_o` out 4: current state code, for debug.

## Operation
- Opcode handling:
  - Opcodes: R 0x00, J 0x02, BEQ 0x04, BNE 0x05, ADDI 0x08, SLTI 0x0A, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B.
  - The opcode is latched into an internal register (`op_q`) in DECODE. All later states decode `op_q`, never `instr_op_i`.
- ALUOp codes: R-type 000, ADD 001, ORI 010, BNE 011, BEQ 100, SLTI 101, LUI 110.
- States, with their codes. Every output not listed is 0.
  - FETCH (0):
    - mem_read=1, iord=0, srcA=0, srcB=01, aluop=001, pc_src=00.
    - Holds until mem_ack_i.
    - In the ack cycle, ir_write=1 and pc_write=1, then go to DECODE.
  - DECODE (1): srcA=0, srcB=11, aluop=001 (branch target into ALUOut). Next state by opcode:
    - LW or SW: MEM_ADDR.
    - R: EXEC_R.
    - ADDI, SLTI, ORI, LUI: EXEC_I.
    - BEQ or BNE: BRANCH.
    - J: JUMP.
    - Any other opcode: FETCH, with illegal_o=1 in this cycle.
  - MEM_ADDR (2): srcA=1, srcB=10, aluop=001. LW goes to MEM_RD; SW goes to MEM_WR.
  - MEM_RD (3): mem_read=1, iord=1. Holds until mem_ack_i, then MEM_WB.
  - MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next: FETCH.
  - MEM_WR (5): mem_write=1, iord=1. Holds until mem_ack_i. In the ack cycle instr_done=1, then FETCH.
  - EXEC_R (6): srcA=1, srcB=00, aluop=000. Next: R_WB.
  - R_WB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next: FETCH.
  - EXEC_I (8): srcA=1, srcB=10. aluop is ADDI 001, SLTI 101, ORI 010, LUI 110. Next: I_WB.
  - I_WB (9): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next: FETCH.
  - BRANCH (10):
    - srcA=1, srcB=00, pc_src=01. aluop is 100 for BEQ, 011 for BNE.
    - pc_write = zero_i.
    - instr_done=1. Next: FETCH.
  - JUMP (11): pc_write=1, pc_src=10, instr_done=1. Next: FETCH.
- Output style:
  - Outputs are combinational from state and `op_q`.
  - pc_write, ir_write and instr_done in the wait states are qualified by `mem_ack_i` or `zero_i` as stated above.
  - mem_read_o and mem_write_o are never both 1.
- Memory handshake:
  - A request stays asserted, with a stable `iord_o`, until the ack cycle inclusive.
  - mem_ack_i is ignored in states that make no request.
- State codes 12–15 are unreachable. If entered, the next state is FETCH and all outputs are 0.

## Timing
- Reset:
  - While rst_i=0: state=FETCH, op_q=0, and every output is forced to 0, including mem_read_o.
  - First request: mem_read_o=1 in the first cycle after rst_i rises.
  - Reset asserted mid-instruction: any request is aborted immediately and no strobe fires.
- Cycles per instruction with zero-wait memory (ack in the same cycle as the request):
  - LW 5, SW 4, R-type 4, I-type 4.
  - BEQ/BNE 3, J 3, illegal 2.
- Each cycle of ack delay adds one cycle.
- Simultaneous events:
  - An ack in FETCH retires the fetch only, then DECODE.
  - In MEM_WR, instr_done and the write complete in the same cycle.

## Structure
- Shared package `ctrl_pkg` holds:
  - the opcode constants;
  - the ALUOp constants, so the ALU controller can use the same names;
  - the 4-bit state encoding;
  - the `alu_src_b` and `pc_src` encodings.
- One sub-module, `alu_op_enc`: combinational (state, op_q) → alu_op_o. It is kept separate so it can be checked against the ALU controller's decode on its own.

## Test plan
- Reset and fetch:
  - Hold rst_i=0 for 3 cycles → all outputs 0, state_o=0.
  - Release rst_i, with mem_ack_i=1 one cycle later → ir_write and pc_write pulse once, and aluop=001 throughout FETCH.
- LW, opcode 0x23, zero-wait → states 0,1,2,3,4. reg_write=1 with mem_to_reg=1 in state 4. Total 5 cycles.
- SW, opcode 0x2B, with ack delayed 3 cycles in MEM_WR → mem_write high for 4 cycles, iord=1 stable, instr_done pulses in the ack cycle.
- Branches:
  - BEQ 0x04 with zero_i=1 → pc_write=1, pc_src=01, aluop=100.
  - BNE 0x05 with zero_i=0 → pc_write=0, aluop=011.
- I-type ALUOp: ADDI, SLTI, ORI, LUI → aluop in EXEC_I is 001, 101, 010, 110 respectively. R-type → 000.
- Illegal opcode 0x3F → illegal_o pulses in DECODE, then FETCH.
- Mid-instruction reset: rst_i=0 during MEM_RD → outputs 0 in the same cycle, and FETCH after release.
